compressor_error_monitor: RTL and testbench

Streaming hardware error-metric accumulator that sits directly downstream of the paired exact and approximate 8:2 compressors. It consumes one (exact_sum, approx_sum) pair per handshake over a fixed window and accumulates:
- mismatch count
- total absolute error distance
- maximum absolute error
Results are held for readout, so ER and MED over long image streams are measured in silicon/FPGA rather than in the testbench.

---
 rtl/cmp_metrics_pkg.sv | 21 ++
 rtl/err_distance_stage.sv | 84 ++++++++
 rtl/compressor_error_monitor.sv | 187 ++++++++++++++++++
 tb/tb_compressor_error_monitor.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_metrics_pkg.sv
// Shared definitions for the compressor error monitor.
//   SUM_W_DEF    default width of each compressor output
//   mon_state_e  monitor sequencing states
//   acc_width()  width of the absolute-error accumulator for a given window
package cmp_metrics_pkg;

    localparam int SUM_W_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_e;

    // Sum of WINDOW values each at most 2^SUM_W-1 fits in CNT_W+SUM_W bits.
    function automatic int acc_width(input int window, input int sum_w);
        return $clog2(window + 1) + sum_w;
    endfunction

endpackage

// File: rtl/err_distance_stage.sv
// Stage-1 register of the error monitor: on each accepted sample it captures
// whether the exact and approximate sums differ and by how much.
// Optional macro CMP_ERR_BIAS_EN adds the signed difference output.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   capture        a sample pair is transferred this cycle
//   exact_sum      exact compressor output
//   approx_sum     approximate compressor output
//   s1_valid       registered: stage holds a sample
//   s1_mismatch    registered: exact != approx
//   s1_abs_diff    registered: |exact - approx|
//   s1_diff        registered: exact - approx, signed (CMP_ERR_BIAS_EN only)
module err_distance_stage
    import cmp_metrics_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    capture,
    input  logic [SUM_W-1:0]        exact_sum,
    input  logic [SUM_W-1:0]        approx_sum,
    output logic                    s1_valid,
    output logic                    s1_mismatch,
    output logic [SUM_W-1:0]        s1_abs_diff
`ifdef CMP_ERR_BIAS_EN
    ,
    output logic signed [SUM_W:0]   s1_diff
`endif
);

    logic             valid_q,    valid_d;
    logic             mismatch_q, mismatch_d;
    logic [SUM_W-1:0] abs_diff_q, abs_diff_d;
`ifdef CMP_ERR_BIAS_EN
    logic signed [SUM_W:0] diff_q, diff_d;
`endif

    always_comb begin
        valid_d    = capture;
        mismatch_d = mismatch_q;
        abs_diff_d = abs_diff_q;
        if (capture) begin
            mismatch_d = (exact_sum != approx_sum);
            abs_diff_d = (exact_sum >= approx_sum) ? (exact_sum - approx_sum)
                                                   : (approx_sum - exact_sum);
        end
    end

`ifdef CMP_ERR_BIAS_EN
    always_comb begin
        diff_d = diff_q;
        if (capture) begin
            diff_d = $signed({1'b0, exact_sum}) - $signed({1'b0, approx_sum});
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
            abs_diff_q <= '0;
`ifdef CMP_ERR_BIAS_EN
            diff_q     <= '0;
`endif
        end else begin
            valid_q    <= valid_d;
            mismatch_q <= mismatch_d;
            abs_diff_q <= abs_diff_d;
`ifdef CMP_ERR_BIAS_EN
            diff_q     <= diff_d;
`endif
        end
    end

    assign s1_valid    = valid_q;
    assign s1_mismatch = mismatch_q;
    assign s1_abs_diff = abs_diff_q;
`ifdef CMP_ERR_BIAS_EN
    assign s1_diff     = diff_q;
`endif

endmodule

// File: rtl/compressor_error_monitor.sv
// Streaming error-metric accumulator for paired exact/approximate 8:2
// compressor outputs. Accepts WINDOW sample pairs per run and holds the
// mismatch count, total absolute error and maximum absolute error.
// Optional macro CMP_ERR_BIAS_EN adds err_bias_sum, the signed running sum
// of (exact - approx).
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          begin a new run (accepted in IDLE and DONE)
//   in_valid       sample pair valid
//   in_ready       monitor accepts a sample this cycle
//   exact_sum      exact compressor output
//   approx_sum     approximate compressor output
//   busy           run in progress (RUN or DRAIN)
//   done           results final and held
//   sample_count   samples accepted this run
//   err_count      samples with exact != approx
//   abs_err_sum    sum of |exact - approx|
//   max_abs_err    largest |exact - approx|
//   err_bias_sum   signed sum of (exact - approx) (CMP_ERR_BIAS_EN only)
//
// state | meaning
// IDLE  | after reset, nothing measured
// RUN   | accepting samples until WINDOW transfers
// DRAIN | one cycle, last sample moves from stage 1 into accumulators
// DONE  | results held until the next start
module compressor_error_monitor
    import cmp_metrics_pkg::*;
#(
    parameter  int SUM_W  = SUM_W_DEF,
    parameter  int WINDOW = 256,
    localparam int CNT_W  = $clog2(WINDOW + 1),
    localparam int ACC_W  = acc_width(WINDOW, SUM_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SUM_W-1:0]        exact_sum,
    input  logic [SUM_W-1:0]        approx_sum,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        sample_count,
    output logic [CNT_W-1:0]        err_count,
    output logic [ACC_W-1:0]        abs_err_sum,
    output logic [SUM_W-1:0]        max_abs_err
`ifdef CMP_ERR_BIAS_EN
    ,
    output logic signed [ACC_W:0]   err_bias_sum
`endif
);

    localparam logic [CNT_W-1:0] WINDOW_C = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(WINDOW - 1);

    mon_state_e       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [ACC_W-1:0] abs_err_sum_q, abs_err_sum_d;
    logic [SUM_W-1:0] max_abs_err_q, max_abs_err_d;
`ifdef CMP_ERR_BIAS_EN
    logic signed [ACC_W:0] err_bias_sum_q, err_bias_sum_d;
    logic signed [SUM_W:0] s1_diff;
`endif

    logic             xfer;
    logic             s1_valid;
    logic             s1_mismatch;
    logic [SUM_W-1:0] s1_abs_diff;

    // Readiness depends only on registered state so it never loops back
    // through an upstream valid.
    assign in_ready = (state_q == ST_RUN) && (sample_count_q < WINDOW_C);
    assign xfer     = in_valid && in_ready;

    err_distance_stage #(
        .SUM_W (SUM_W)
    ) u_stage1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture     (xfer),
        .exact_sum   (exact_sum),
        .approx_sum  (approx_sum),
        .s1_valid    (s1_valid),
        .s1_mismatch (s1_mismatch),
        .s1_abs_diff (s1_abs_diff)
`ifdef CMP_ERR_BIAS_EN
        ,
        .s1_diff     (s1_diff)
`endif
    );

    always_comb begin
        state_d        = state_q;
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        abs_err_sum_d  = abs_err_sum_q;
        max_abs_err_d  = max_abs_err_q;
`ifdef CMP_ERR_BIAS_EN
        err_bias_sum_d = err_bias_sum_q;
`endif

        // Stage 2: fold the registered sample into the accumulators.
        if (s1_valid) begin
            err_count_d   = err_count_q + CNT_W'(s1_mismatch);
            abs_err_sum_d = abs_err_sum_q + ACC_W'(s1_abs_diff);
            if (s1_abs_diff > max_abs_err_q) begin
                max_abs_err_d = s1_abs_diff;
            end
`ifdef CMP_ERR_BIAS_EN
            err_bias_sum_d = err_bias_sum_q
                           + $signed({{CNT_W{s1_diff[SUM_W]}}, s1_diff});
`endif
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d        = ST_RUN;
                    sample_count_d = '0;
                    err_count_d    = '0;
                    abs_err_sum_d  = '0;
                    max_abs_err_d  = '0;
`ifdef CMP_ERR_BIAS_EN
                    err_bias_sum_d = '0;
`endif
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    sample_count_d = sample_count_q + 1'b1;
                    if (sample_count_q == LAST_C) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            abs_err_sum_q  <= '0;
            max_abs_err_q  <= '0;
`ifdef CMP_ERR_BIAS_EN
            err_bias_sum_q <= '0;
`endif
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            abs_err_sum_q  <= abs_err_sum_d;
            max_abs_err_q  <= max_abs_err_d;
`ifdef CMP_ERR_BIAS_EN
            err_bias_sum_q <= err_bias_sum_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign abs_err_sum  = abs_err_sum_q;
    assign max_abs_err  = max_abs_err_q;
`ifdef CMP_ERR_BIAS_EN
    assign err_bias_sum = err_bias_sum_q;
`endif

endmodule

// File: tb/tb_compressor_error_monitor.sv
module tb_compressor_error_monitor;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic [1:0] exact_sum, approx_sum;
    logic start_a, start_b, start_c;

    // a: WINDOW=4, b: WINDOW=256, c: WINDOW=1
    logic rdy_a, busy_a, done_a;
    logic [2:0] sc_a, ec_a;
    logic [4:0] abs_a;
    logic [1:0] max_a;
    logic rdy_b, busy_b, done_b;
    logic [8:0] sc_b, ec_b;
    logic [10:0] abs_b;
    logic [1:0] max_b;
    logic rdy_c, busy_c, done_c;
    logic [0:0] sc_c, ec_c;
    logic [2:0] abs_c;
    logic [1:0] max_c;
`ifdef CMP_ERR_BIAS_EN
    logic signed [5:0]  bias_a;
    logic signed [11:0] bias_b;
    logic signed [3:0]  bias_c;
`endif

    int sel;
    logic o_ready, o_busy, o_done;
    logic [15:0] o_sc, o_ec, o_abs, o_max;
    logic signed [15:0] o_bias;
    logic [66:0] obs;

    int vectors = 0;
    int miscompares = 0;
    int ready_bad = 0;

    always #5 clk = ~clk;

    compressor_error_monitor #(.SUM_W(2), .WINDOW(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid),
        .in_ready(rdy_a), .exact_sum(exact_sum), .approx_sum(approx_sum),
        .busy(busy_a), .done(done_a), .sample_count(sc_a), .err_count(ec_a),
        .abs_err_sum(abs_a), .max_abs_err(max_a)
`ifdef CMP_ERR_BIAS_EN
        , .err_bias_sum(bias_a)
`endif
    );

    compressor_error_monitor #(.SUM_W(2), .WINDOW(256)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid),
        .in_ready(rdy_b), .exact_sum(exact_sum), .approx_sum(approx_sum),
        .busy(busy_b), .done(done_b), .sample_count(sc_b), .err_count(ec_b),
        .abs_err_sum(abs_b), .max_abs_err(max_b)
`ifdef CMP_ERR_BIAS_EN
        , .err_bias_sum(bias_b)
`endif
    );

    compressor_error_monitor #(.SUM_W(2), .WINDOW(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .in_valid(in_valid),
        .in_ready(rdy_c), .exact_sum(exact_sum), .approx_sum(approx_sum),
        .busy(busy_c), .done(done_c), .sample_count(sc_c), .err_count(ec_c),
        .abs_err_sum(abs_c), .max_abs_err(max_c)
`ifdef CMP_ERR_BIAS_EN
        , .err_bias_sum(bias_c)
`endif
    );

    always_comb begin
        o_ready = 1'b0; o_busy = 1'b0; o_done = 1'b0;
        o_sc = '0; o_ec = '0; o_abs = '0; o_max = '0; o_bias = '0;
        case (sel)
            0: begin
                o_ready = rdy_a; o_busy = busy_a; o_done = done_a;
                o_sc = 16'(sc_a); o_ec = 16'(ec_a); o_abs = 16'(abs_a); o_max = 16'(max_a);
`ifdef CMP_ERR_BIAS_EN
                o_bias = 16'(bias_a);
`endif
            end
            1: begin
                o_ready = rdy_b; o_busy = busy_b; o_done = done_b;
                o_sc = 16'(sc_b); o_ec = 16'(ec_b); o_abs = 16'(abs_b); o_max = 16'(max_b);
`ifdef CMP_ERR_BIAS_EN
                o_bias = 16'(bias_b);
`endif
            end
            default: begin
                o_ready = rdy_c; o_busy = busy_c; o_done = done_c;
                o_sc = 16'(sc_c); o_ec = 16'(ec_c); o_abs = 16'(abs_c); o_max = 16'(max_c);
`ifdef CMP_ERR_BIAS_EN
                o_bias = 16'(bias_c);
`endif
            end
        endcase
        obs = {o_sc, o_ec, o_abs, o_max, o_busy, o_done, o_ready};
    end

    // Reference model: metrics of the first n_acc pairs, plain integer arithmetic.
    function automatic logic [66:0] exp_obs(input int pe[$], input int pa[$], input int n_acc,
                                            input int sc, input logic busy, input logic done,
                                            input logic ready);
        int ec = 0;
        int ab = 0;
        int mx = 0;
        for (int i = 0; i < n_acc; i++) begin
            int d = pe[i] - pa[i];
            if (d < 0) d = -d;
            if (d != 0) ec++;
            ab += d;
            if (d > mx) mx = d;
        end
        return {16'(sc), 16'(ec), 16'(ab), 16'(mx), busy, done, ready};
    endfunction

    function automatic int exp_bias(input int pe[$], input int pa[$], input int n_acc);
        int b = 0;
        for (int i = 0; i < n_acc; i++) b += pe[i] - pa[i];
        return b;
    endfunction

    function automatic int exact_compressor_8_2(input logic [7:0] x);
        return $countones(x) % 4;
    endfunction

    function automatic int approx_compressor_8_2_v1(input logic [7:0] x);
        logic s, c;
        s = (x[0] | x[1]) ^ (x[2] | x[3]) ^ (x[4] | x[5]) ^ (x[6] | x[7]);
        c = (x[0] & x[1]) | (x[2] & x[3]) | (x[4] & x[5]) | (x[6] & x[7]);
        return int'({c, s});
    endfunction

    task automatic pulse_start();
        case (sel)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Call at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic xfer_pair(input int e, input int a);
        in_valid = 1'b1; exact_sum = 2'(e); approx_sum = 2'(a);
        @(negedge clk);
        if (o_ready !== 1'b1) ready_bad++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exact_sum = 2'($urandom_range(0, 3)); approx_sum = 2'($urandom_range(0, 3));
    endtask

    task automatic drive_pairs(input int pe[$], input int pa[$], input int gmin, input int gmax);
        for (int i = 0; i < pe.size(); i++) begin
            idle_cycles(int'($urandom_range(gmin, gmax)));
            xfer_pair(pe[i], pa[i]);
        end
    endtask

    task automatic test_reset();
        int pe[$];
        int pa[$];
        logic [66:0] e;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            vectors++; e = exp_obs(pe, pa, 0, 0, 0, 0, 0);
            if (obs !== e) begin miscompares++; $display("FAIL reset_state dut%0d obs=%h exp=%h", s, obs, e); end
        end
        sel = 0;
        @(posedge clk); #1;
        pulse_start();
        xfer_pair(1, 3); xfer_pair(2, 0);
        @(negedge clk); rst_n = 1'b0; #1;
        vectors++; e = exp_obs(pe, pa, 0, 0, 0, 0, 0);
        if (obs !== e) begin miscompares++; $display("FAIL reset_midrun obs=%h exp=%h", obs, e); end
`ifdef CMP_ERR_BIAS_EN
        vectors++;
        if (o_bias !== 16'sd0) begin miscompares++; $display("FAIL reset_bias obs=%0d exp=0", o_bias); end
`endif
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;
        ready_bad = 0;
        for (int i = 0; i < 4; i++) begin
            pe.push_back(int'($urandom_range(0, 3))); pa.push_back(int'($urandom_range(0, 3)));
        end
        pulse_start();
        drive_pairs(pe, pa, 0, 0);
        @(negedge clk);
        vectors++; e = exp_obs(pe, pa, 3, 4, 1, 0, 0);
        if (obs !== e) begin miscompares++; $display("FAIL reset_clean_drain obs=%h exp=%h", obs, e); end
        @(negedge clk);
        vectors++; e = exp_obs(pe, pa, 4, 4, 0, 1, 0);
        if (obs !== e) begin miscompares++; $display("FAIL reset_clean_done obs=%h exp=%h", obs, e); end
        vectors++;
        if (ready_bad !== 0) begin miscompares++; $display("FAIL reset_clean_ready stalls=%0d exp=0", ready_bad); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed(input int gap);
        int pe[$] = '{2, 3, 1, 0};
        int pa[$] = '{2, 1, 2, 3};
        logic [66:0] e;
        sel = 0; ready_bad = 0;
        pulse_start();
        drive_pairs(pe, pa, gap, gap);
        @(negedge clk);
        vectors++; e = {16'd4, 16'd2, 16'd3, 16'd2, 1'b1, 1'b0, 1'b0};
        if (obs !== e) begin miscompares++; $display("FAIL directed_drain gap=%0d obs=%h exp=%h", gap, obs, e); end
        @(negedge clk);
        vectors++; e = {16'd4, 16'd3, 16'd6, 16'd3, 1'b0, 1'b1, 1'b0};
        if (obs !== e) begin miscompares++; $display("FAIL directed_done gap=%0d obs=%h exp=%h", gap, obs, e); end
`ifdef CMP_ERR_BIAS_EN
        vectors++;
        if (o_bias !== -16'sd2) begin miscompares++; $display("FAIL directed_bias obs=%0d exp=-2", o_bias); end
`endif
        vectors++;
        if (ready_bad !== 0) begin miscompares++; $display("FAIL directed_ready stalls=%0d exp=0", ready_bad); end
        @(posedge clk); #1;
        if (gap != 0) begin
            // offer a 5th pair in DONE; must be ignored
            in_valid = 1'b1; exact_sum = 2'd3; approx_sum = 2'd0;
            idle_cycles(3);
            @(negedge clk);
            vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL gaps_extra_pair obs=%h exp=%h", obs, e); end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic test_restart();
        int pe[$];
        int pa[$];
        int ones[$] = '{1, 1, 1, 1};
        logic [66:0] e;
        sel = 0; ready_bad = 0;
        for (int i = 0; i < 4; i++) begin
            pe.push_back(int'($urandom_range(0, 3))); pa.push_back(int'($urandom_range(0, 3)));
        end
        pulse_start();
        xfer_pair(pe[0], pa[0]); xfer_pair(pe[1], pa[1]);
        pulse_start();
        xfer_pair(pe[2], pa[2]); xfer_pair(pe[3], pa[3]);
        @(negedge clk); @(negedge clk);
        vectors++; e = exp_obs(pe, pa, 4, 4, 0, 1, 0);
        if (obs !== e) begin miscompares++; $display("FAIL restart_busy_ignored obs=%h exp=%h", obs, e); end
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        vectors++; e = exp_obs(pe, pa, 0, 0, 1, 0, 1);
        if (obs !== e) begin miscompares++; $display("FAIL restart_clear obs=%h exp=%h", obs, e); end
`ifdef CMP_ERR_BIAS_EN
        vectors++;
        if (o_bias !== 16'sd0) begin miscompares++; $display("FAIL restart_bias_clear obs=%0d exp=0", o_bias); end
`endif
        @(posedge clk); #1;
        drive_pairs(ones, ones, 0, 1);
        @(negedge clk); @(negedge clk);
        vectors++; e = exp_obs(ones, ones, 4, 4, 0, 1, 0);
        if (obs !== e) begin miscompares++; $display("FAIL restart_equal_pairs obs=%h exp=%h", obs, e); end
        vectors++;
        if (ready_bad !== 0) begin miscompares++; $display("FAIL restart_ready stalls=%0d exp=0", ready_bad); end
        @(posedge clk); #1;
    endtask

    task automatic test_random_windows();
        logic [66:0] e;
        sel = 0;
        for (int w = 0; w < 6; w++) begin
            int pe[$];
            int pa[$];
            ready_bad = 0;
            for (int i = 0; i < 4; i++) begin
                pe.push_back(int'($urandom_range(0, 3))); pa.push_back(int'($urandom_range(0, 3)));
            end
            pulse_start();
            drive_pairs(pe, pa, 0, 2);
            @(negedge clk);
            vectors++; e = exp_obs(pe, pa, 3, 4, 1, 0, 0);
            if (obs !== e) begin miscompares++; $display("FAIL random_drain w=%0d obs=%h exp=%h", w, obs, e); end
            @(negedge clk);
            vectors++; e = exp_obs(pe, pa, 4, 4, 0, 1, 0);
            if (obs !== e) begin miscompares++; $display("FAIL random_done w=%0d obs=%h exp=%h", w, obs, e); end
`ifdef CMP_ERR_BIAS_EN
            vectors++;
            if (o_bias !== 16'(exp_bias(pe, pa, 4))) begin
                miscompares++; $display("FAIL random_bias w=%0d obs=%0d exp=%0d", w, o_bias, exp_bias(pe, pa, 4));
            end
`endif
            vectors++;
            if (ready_bad !== 0) begin miscompares++; $display("FAIL random_ready w=%0d stalls=%0d exp=0", w, ready_bad); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sweep();
        int pe[$];
        int pa[$];
        logic [66:0] e;
        sel = 1; ready_bad = 0;
        for (int v = 0; v < 256; v++) begin
            pe.push_back(exact_compressor_8_2(8'(v)));
            pa.push_back(approx_compressor_8_2_v1(8'(v)));
        end
        pulse_start();
        drive_pairs(pe, pa, 0, 2);
        @(negedge clk);
        vectors++; e = exp_obs(pe, pa, 255, 256, 1, 0, 0);
        if (obs !== e) begin miscompares++; $display("FAIL sweep_drain obs=%h exp=%h", obs, e); end
        @(negedge clk);
        vectors++; e = exp_obs(pe, pa, 256, 256, 0, 1, 0);
        if (obs !== e) begin miscompares++; $display("FAIL sweep_done obs=%h exp=%h", obs, e); end
`ifdef CMP_ERR_BIAS_EN
        vectors++;
        if (o_bias !== 16'(exp_bias(pe, pa, 256))) begin
            miscompares++; $display("FAIL sweep_bias obs=%0d exp=%0d", o_bias, exp_bias(pe, pa, 256));
        end
`endif
        vectors++;
        if (ready_bad !== 0) begin miscompares++; $display("FAIL sweep_ready stalls=%0d exp=0", ready_bad); end
        @(posedge clk); #1;
    endtask

    task automatic test_window1();
        int pe[$] = '{0};
        int pa[$] = '{3};
        logic [66:0] e;
        sel = 2; ready_bad = 0;
        pulse_start();
        xfer_pair(0, 3);
        @(negedge clk);
        vectors++; e = exp_obs(pe, pa, 0, 1, 1, 0, 0);
        if (obs !== e) begin miscompares++; $display("FAIL window1_drain obs=%h exp=%h", obs, e); end
        @(negedge clk);
        vectors++; e = {16'd1, 16'd1, 16'd3, 16'd3, 1'b0, 1'b1, 1'b0};
        if (obs !== e) begin miscompares++; $display("FAIL window1_done obs=%h exp=%h", obs, e); end
`ifdef CMP_ERR_BIAS_EN
        vectors++;
        if (o_bias !== -16'sd3) begin miscompares++; $display("FAIL window1_bias obs=%0d exp=-3", o_bias); end
`endif
        vectors++;
        if (ready_bad !== 0) begin miscompares++; $display("FAIL window1_ready stalls=%0d exp=0", ready_bad); end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; exact_sum = '0; approx_sum = '0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; sel = 0;
        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_directed(0);
        test_directed(3);
        test_restart();
        test_random_windows();
        test_sweep();
        test_window1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
